wb_commit: RTL
==============

# wb_commit

Commit and sequencing block at the receiving end of the write-back interface. Generates the one-hot four-phase `start` ring that drives the fetch/decode/execute/write stages. At the end of each write phase, samples `reg_update`/`reg_new` and `pc_update`/`pc_new` and applies them to the architectural register file and the program counter. Owns PC, the 32×32 register file, and the retired-instruction counter.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000: PC value after reset.
- `PC_STEP`, 4: sequential PC increment.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `run`  in  1  enable sequencing; level-sensitive.
- `halt`  in  1  stop after the current instruction commits.
- `start`  out  4  one-hot phase ring: bit0 fetch, bit1 decode, bit2 execute, bit3 write.
- `reg_update`  in  1  write stage requests register write.
- `reg_new`  in  32  register write data.
- `rd_addr`  in  5  destination register, held stable by decode through P3.
- `pc_update`  in  1  write stage requests PC load (taken branch/jump).
- `pc_new`  in  32  PC target.
- `rs_addr`, `rt_addr`  in  5 each  read addresses.
- `rs_data`, `rt_data`  out  32 each  combinational read data; r0 reads 0.
- `pc`  out  32  current PC.
- `commit`  out  1  high during the P3 (write) cycle.
- `retired`  out  32  count of committed instructions.
- `running`  out  1  high whenever state ≠ IDLE.

## Operation
States:
- IDLE: `start`=0000.
- P0: 0001.
- P1: 0010.
- P2: 0100.
- P3: 1000.

Transitions:
- IDLE→P0 when `run`=1 and `halt`=0.
- P0→P1→P2→P3 unconditionally.
- P3→P0 if `run`=1 and `halt`=0; otherwise P3→IDLE.
- `run` or `halt` seen in P0–P2 has no effect until the P3 decision. An instruction in flight always completes.

Commit (clock edge leaving P3):
- `pc_update`=1: `pc` ← `pc_new`.
- `pc_update`=0: `pc` ← `pc + PC_STEP`, 32-bit modulo (FFFF_FFFC+4 = 0).
- `reg_update`=1 and `rd_addr`≠0: `regs[rd_addr]` ← `reg_new`. Writes to r0 are discarded.
- Both update flags high: both are applied in the same edge.
- `retired` increments by 1, wrapping at 2^32.

Update inputs are ignored outside P3. Reads are asynchronous with no bypass; the commit is visible from the next P0.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state IDLE, `start`=0000;
  - `pc`=`PC_RESET`, `retired`=0, all registers 0;
  - `commit`=0, `running`=0.
- Reset overrides any in-progress instruction. No partial commit occurs: if reset coincides with the P3 exit edge, reset wins.
- Instruction period is exactly 4 cycles back-to-back.
- First `start`=0001 appears one cycle after `run` is sampled high in IDLE.
- The write stage latches on the `start[3]` rising edge, so `reg_*`/`pc_*` settle within the P3 cycle and are sampled at the edge ending P3.
- `commit` equals `start[3]`.
- `pc` and register values change only on the P3 exit edge or on reset.

## Structure
- Shared package holds:
  - phase one-hot constants `PH_IDLE`, `PH_FETCH`, `PH_DECODE`, `PH_EXEC`, `PH_WRITE`;
  - `XLEN`=32 and `REG_AW`=5, shared with the write stage and decoder.
- Sub-module `regfile`: 32×32, one synchronous write port with a write enable, two asynchronous read ports, r0 hardwired to zero.
- `wb_commit` contains the phase FSM, PC register, retired counter and commit gating.

## Test plan
- Reset then `run`=1 for 12 cycles, no updates → `start` cycles 0001,0010,0100,1000 three times; `pc`=0x0C; `retired`=3.
- During P3: `reg_update`=1, `rd_addr`=5, `reg_new`=0xDEADBEEF → from the next P0, `rs_addr`=5 reads 0xDEADBEEF. Same sequence with `rd_addr`=0 → r0 still reads 0.
- During P3: `pc_update`=1, `pc_new`=0x0000_0100 → `pc`=0x100 after the edge, not 0x04. Assert `pc_update` in P1 only → ignored, `pc`=0x04.
- Raise `halt` in P1 → instruction completes, `retired`+1, then IDLE with `start`=0000. Deassert `halt` → P0 resumes with `pc` unchanged.
- Both flags in one P3 (`rd_addr`=3, `reg_new`=7, `pc_new`=0x40) → r3=7 and `pc`=0x40. Preload `pc`=0xFFFF_FFFC then commit with no `pc_update` → `pc`=0.
- Drop `rst_n` in P2 after several register writes → next cycle IDLE, `pc`=`PC_RESET`, all registers read 0, `retired`=0, no stray commit.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the write-back commit block, write stage and decoder:
// datapath widths, the one-hot phase ring encoding and the PC advance rule.
package wb_commit_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [3:0] PH_IDLE   = 4'b0000;
  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_WRITE  = 4'b1000;

  // State codes are the phase codes, so the state register drives start directly.
  typedef enum logic [3:0] {
    ST_IDLE = PH_IDLE,
    ST_P0   = PH_FETCH,
    ST_P1   = PH_DECODE,
    ST_P2   = PH_EXEC,
    ST_P3   = PH_WRITE
  } phase_e;

  // Redirect wins over the sequential step; the addition wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_advance(
    input logic [XLEN-1:0] cur,
    input logic            redirect,
    input logic [XLEN-1:0] target,
    input logic [XLEN-1:0] step
  );
    return redirect ? target : cur + step;
  endfunction

endpackage

// File: rtl/wb_commit_regfile.sv
// Architectural register file: one synchronous write port, two asynchronous read ports.
// r0 is hardwired to zero; reads see no bypass of a same-cycle write.
module regfile
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rd_a_addr,
  output logic [XLEN-1:0]   rd_a_data,
  input  logic [REG_AW-1:0] rd_b_addr,
  output logic [XLEN-1:0]   rd_b_data
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = (rd_a_addr == '0) ? '0 : mem[rd_a_addr];
  assign rd_b_data = (rd_b_addr == '0) ? '0 : mem[rd_b_addr];

endmodule

// File: rtl/wb_commit.sv
// Four-phase sequencer that commits register/PC updates on the edge leaving the write phase.
// One instruction per 4 cycles; run/halt are only consulted at idle and at the end of write.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt,
  output logic [3:0]        start,
  input  logic              reg_update,
  input  logic [XLEN-1:0]   reg_new,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              pc_update,
  input  logic [XLEN-1:0]   pc_new,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  output logic [XLEN-1:0]   pc,
  output logic              commit,
  output logic [XLEN-1:0]   retired,
  output logic              running
);

  phase_e state;
  logic   go;
  logic   rf_wr_en;

  assign go = run && !halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= PC_RESET;
      retired <= '0;
    end else begin
      case (state)
        ST_IDLE: if (go) state <= ST_P0;
        ST_P0:   state <= ST_P1;
        ST_P1:   state <= ST_P2;
        ST_P2:   state <= ST_P3;
        ST_P3: begin
          state   <= go ? ST_P0 : ST_IDLE;
          pc      <= pc_advance(pc, pc_update, pc_new, PC_STEP);
          retired <= retired + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The write port is gated to P3 so stray update strobes in other phases are ignored.
  assign rf_wr_en = (state == ST_P3) && reg_update;

  regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rf_wr_en),
    .wr_addr   (rd_addr),
    .wr_data   (reg_new),
    .rd_a_addr (rs_addr),
    .rd_a_data (rs_data),
    .rd_b_addr (rt_addr),
    .rd_b_data (rt_data)
  );

  assign start   = state;
  assign commit  = (state == ST_P3);
  assign running = (state != ST_IDLE);

endmodule
